// File: rtl/hazard_control_unit_pkg.sv
// ----------------------------------------------------------------------------
// hazard_control_unit_pkg
//   Shared pipeline definitions for the hazard controller:
//     hcu_state_e       - controller state (RUN, LOAD_STALL)
//     REG_ZERO          - architectural x0, never a real producer
//     CNT_W_DEFAULT     - default performance counter width
//     load_use_hazard() - load-use dependence test between EX and ID
// ----------------------------------------------------------------------------
package hazard_control_unit_pkg;

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } hcu_state_e;

  localparam logic [4:0]  REG_ZERO      = 5'd0;
  localparam int unsigned CNT_W_DEFAULT = 32;

  // A load in EX whose destination is read by the instruction in ID.
  // Writes to x0 are discarded by the register file, so they never stall.
  function automatic logic load_use_hazard(
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic [4:0] rd,
    input logic       rs1_used,
    input logic       rs2_used,
    input logic       is_load
  );
    return is_load && (rd != REG_ZERO) &&
           ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Width-parameterized event counter that sticks at all-ones.
//   Ports:
//     i_clk      - clock, rising edge
//     i_reset_n  - asynchronous active-low reset (count -> 0)
//     i_inc      - count one event this cycle
//     i_clear    - synchronous clear, wins over i_inc
//     o_count    - current count
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_inc,
  input  logic         i_clear,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// ----------------------------------------------------------------------------
// hazard_control_unit
//   Stall/flush controller for the 5-stage RV32 pipeline. Detects load-use
//   dependences in ID and inserts LOAD_BUBBLES bubbles, squashes wrong-path
//   instructions on a taken branch, and freezes the pipeline while data
//   memory is busy. Priority: freeze > flush > load stall.
//   Parameters:
//     LOAD_BUBBLES - bubbles per load-use hazard (legal 1..3)
//     CNT_W        - performance counter width
//   Ports:
//     i_clk, i_reset_n             - clock, async active-low reset
//     i_rs1_ID, i_rs2_ID           - ID source registers
//     i_rs1_used_ID, i_rs2_used_ID - ID instruction really reads that source
//     i_rd_EX, i_load_EX           - EX destination / EX is a load
//     i_branch_taken_EX            - taken branch/jump resolved in EX
//     i_dmem_busy                  - MEM access cannot complete this cycle
//     i_perf_clear                 - synchronous clear of both counters
//     o_stall_PC, o_stall_IF_ID, o_stall_ID_EX - register hold enables
//     o_bubble_ID_EX               - load a NOP into ID/EX
//     o_flush_IF_ID, o_flush_ID_EX - clear to NOP
//     o_freeze_MEM                 - hold EX/MEM and MEM/WB
//     o_stall_cycles               - cycles with o_stall_PC high (saturating)
//     o_flush_events               - taken-branch flushes (saturating)
// ----------------------------------------------------------------------------
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned CNT_W        = CNT_W_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [4:0]       i_rs1_ID,
  input  logic [4:0]       i_rs2_ID,
  input  logic             i_rs1_used_ID,
  input  logic             i_rs2_used_ID,
  input  logic [4:0]       i_rd_EX,
  input  logic             i_load_EX,
  input  logic             i_branch_taken_EX,
  input  logic             i_dmem_busy,
  input  logic             i_perf_clear,
  output logic             o_stall_PC,
  output logic             o_stall_IF_ID,
  output logic             o_stall_ID_EX,
  output logic             o_bubble_ID_EX,
  output logic             o_flush_IF_ID,
  output logic             o_flush_ID_EX,
  output logic             o_freeze_MEM,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_events
);

  // The first bubble is issued from RUN; LOAD_STALL covers the rest.
  localparam logic [1:0] BUBBLE_RELOAD = 2'(LOAD_BUBBLES - 1);

  hcu_state_e r_state;
  hcu_state_e w_state_next;
  logic [1:0] r_bcnt;
  logic [1:0] w_bcnt_next;
  logic       w_hazard;

  assign w_hazard = load_use_hazard(i_rs1_ID, i_rs2_ID, i_rd_EX,
                                    i_rs1_used_ID, i_rs2_used_ID, i_load_EX);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= RUN;
      r_bcnt  <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_bcnt  <= w_bcnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_bcnt_next    = r_bcnt;
    o_stall_PC     = 1'b0;
    o_stall_IF_ID  = 1'b0;
    o_stall_ID_EX  = 1'b0;
    o_bubble_ID_EX = 1'b0;
    o_flush_IF_ID  = 1'b0;
    o_flush_ID_EX  = 1'b0;
    o_freeze_MEM   = 1'b0;

    if (i_dmem_busy) begin
      // Whole pipeline holds; state and bubble count are left untouched so
      // a pending load stall resumes exactly where it was.
      o_stall_PC    = 1'b1;
      o_stall_IF_ID = 1'b1;
      o_stall_ID_EX = 1'b1;
      o_freeze_MEM  = 1'b1;
    end else if (i_branch_taken_EX) begin
      // The ID instruction is wrong-path, so any stall it caused is moot.
      o_flush_IF_ID = 1'b1;
      o_flush_ID_EX = 1'b1;
      w_state_next  = RUN;
      w_bcnt_next   = 2'd0;
    end else if (r_state == LOAD_STALL) begin
      // EX already holds a bubble here, so the hazard input is not consulted.
      o_stall_PC     = 1'b1;
      o_stall_IF_ID  = 1'b1;
      o_bubble_ID_EX = 1'b1;
      w_bcnt_next    = r_bcnt - 2'd1;
      if (r_bcnt == 2'd1) begin
        w_state_next = RUN;
      end
    end else if (w_hazard) begin
      o_stall_PC     = 1'b1;
      o_stall_IF_ID  = 1'b1;
      o_bubble_ID_EX = 1'b1;
      if (LOAD_BUBBLES > 1) begin
        w_state_next = LOAD_STALL;
        w_bcnt_next  = BUBBLE_RELOAD;
      end
    end
  end

  // Performance counters: [0] stall cycles, [1] flush events.
  logic [1:0]       w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_val [2];

  assign w_cnt_inc[0] = o_stall_PC;
  assign w_cnt_inc[1] = o_flush_IF_ID;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
      sat_counter #(
        .W (CNT_W)
      ) u_cnt (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_inc     (w_cnt_inc[gi]),
        .i_clear   (i_perf_clear),
        .o_count   (w_cnt_val[gi])
      );
    end
  endgenerate

  assign o_stall_cycles = w_cnt_val[0];
  assign o_flush_events = w_cnt_val[1];

endmodule

// File: tb/tb_hazard_control_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_control_unit
//   Three controllers share one stimulus stream:
//     k=0 : LOAD_BUBBLES=2, CNT_W=32
//     k=1 : LOAD_BUBBLES=3, CNT_W=32
//     k=2 : LOAD_BUBBLES=1, CNT_W=4
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
//   Control outputs are packed as {stall_PC, stall_IF_ID, stall_ID_EX,
//   bubble_ID_EX, flush_IF_ID, flush_ID_EX, freeze_MEM}.
// ----------------------------------------------------------------------------
module tb_hazard_control_unit;

  localparam logic [6:0] C_IDLE   = 7'b0000000;
  localparam logic [6:0] C_STALL  = 7'b1101000;
  localparam logic [6:0] C_FLUSH  = 7'b0000110;
  localparam logic [6:0] C_FREEZE = 7'b1110001;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, load, br, busy, pclr;

  logic spc [3];
  logic sif [3];
  logic sid [3];
  logic bub [3];
  logic fif [3];
  logic fid [3];
  logic frz [3];
  logic [31:0] sc0, fe0, sc1, fe1;
  logic [3:0]  sc2, fe2;

  always #5 clk = ~clk;

  hazard_control_unit #(.LOAD_BUBBLES(2), .CNT_W(32)) dut0 (
    .i_clk(clk), .i_reset_n(reset_n), .i_rs1_ID(rs1), .i_rs2_ID(rs2),
    .i_rs1_used_ID(u1), .i_rs2_used_ID(u2), .i_rd_EX(rd), .i_load_EX(load),
    .i_branch_taken_EX(br), .i_dmem_busy(busy), .i_perf_clear(pclr),
    .o_stall_PC(spc[0]), .o_stall_IF_ID(sif[0]), .o_stall_ID_EX(sid[0]),
    .o_bubble_ID_EX(bub[0]), .o_flush_IF_ID(fif[0]), .o_flush_ID_EX(fid[0]),
    .o_freeze_MEM(frz[0]), .o_stall_cycles(sc0), .o_flush_events(fe0));

  hazard_control_unit #(.LOAD_BUBBLES(3), .CNT_W(32)) dut1 (
    .i_clk(clk), .i_reset_n(reset_n), .i_rs1_ID(rs1), .i_rs2_ID(rs2),
    .i_rs1_used_ID(u1), .i_rs2_used_ID(u2), .i_rd_EX(rd), .i_load_EX(load),
    .i_branch_taken_EX(br), .i_dmem_busy(busy), .i_perf_clear(pclr),
    .o_stall_PC(spc[1]), .o_stall_IF_ID(sif[1]), .o_stall_ID_EX(sid[1]),
    .o_bubble_ID_EX(bub[1]), .o_flush_IF_ID(fif[1]), .o_flush_ID_EX(fid[1]),
    .o_freeze_MEM(frz[1]), .o_stall_cycles(sc1), .o_flush_events(fe1));

  hazard_control_unit #(.LOAD_BUBBLES(1), .CNT_W(4)) dut2 (
    .i_clk(clk), .i_reset_n(reset_n), .i_rs1_ID(rs1), .i_rs2_ID(rs2),
    .i_rs1_used_ID(u1), .i_rs2_used_ID(u2), .i_rd_EX(rd), .i_load_EX(load),
    .i_branch_taken_EX(br), .i_dmem_busy(busy), .i_perf_clear(pclr),
    .o_stall_PC(spc[2]), .o_stall_IF_ID(sif[2]), .o_stall_ID_EX(sid[2]),
    .o_bubble_ID_EX(bub[2]), .o_flush_IF_ID(fif[2]), .o_flush_ID_EX(fid[2]),
    .o_freeze_MEM(frz[2]), .o_stall_cycles(sc2), .o_flush_events(fe2));

  // ---------------- reference model ----------------
  int              total = 0;
  int              bad   = 0;
  int              lb   [3] = '{2, 3, 1};
  longint unsigned cmax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  int              rem  [3];   // bubbles still owed after the current cycle
  longint unsigned mcs  [3];
  longint unsigned mfe  [3];

  function automatic bit hz();
    return load && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
  endfunction

  function automatic logic [6:0] exp_ctrl(input int k);
    if (busy)             return C_FREEZE;
    if (br)               return C_FLUSH;
    if (rem[k] > 0 || hz()) return C_STALL;
    return C_IDLE;
  endfunction

  function automatic logic [6:0] ctrl_of(input int k);
    return {spc[k], sif[k], sid[k], bub[k], fif[k], fid[k], frz[k]};
  endfunction

  function automatic logic [31:0] cnt_act(input int k, input bit flush);
    case (k)
      0:       return flush ? fe0 : sc0;
      1:       return flush ? fe1 : sc1;
      default: return flush ? {28'd0, fe2} : {28'd0, sc2};
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      rem[k] = 0; mcs[k] = 0; mfe[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      logic [6:0] c;
      c = exp_ctrl(k);
      if (pclr) begin
        mcs[k] = 0; mfe[k] = 0;
      end else begin
        if (c[6] && mcs[k] < cmax[k]) mcs[k]++;
        if (c[2] && mfe[k] < cmax[k]) mfe[k]++;
      end
      if (busy)            ;
      else if (br)         rem[k] = 0;
      else if (rem[k] > 0) rem[k]--;
      else if (hz())       rem[k] = lb[k] - 1;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    u1 = 1'b0; u2 = 1'b0; load = 1'b0; br = 1'b0; busy = 1'b0; pclr = 1'b0;
  endtask

  task automatic set_hz();
    set_idle();
    load = 1'b1; rd = 5'd5; rs1 = 5'd5; u1 = 1'b1;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic sample(input string tag);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_ctrl%0d", tag, k), {25'd0, ctrl_of(k)}, {25'd0, exp_ctrl(k)});
      check($sformatf("%s_stallcnt%0d", tag, k), cnt_act(k, 1'b0), 32'(mcs[k]));
      check($sformatf("%s_flushcnt%0d", tag, k), cnt_act(k, 1'b1), 32'(mfe[k]));
    end
    $display("[%s] ld=%b rd=%0d rs1=%0d/%b rs2=%0d/%b br=%b busy=%b clr=%b | ctrl=%b/%b/%b sc=%0d/%0d/%0d fe=%0d/%0d/%0d",
             tag, load, rd, rs1, u1, rs2, u2, br, busy, pclr,
             ctrl_of(0), ctrl_of(1), ctrl_of(2), sc0, sc1, sc2, fe0, fe1, fe2);
  endtask

  task automatic adv();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cycle(input string tag);
    sample(tag);
    adv();
  endtask

  task automatic do_reset();
    set_idle();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- single-cycle vectors from RUN (k=0) ----------------
  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, load, br, busy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{"rs1_match",   5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 0, C_STALL};
    vecs[1] = '{"rd_zero",     5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, C_IDLE};
    vecs[2] = '{"rs2_unused",  5'd3, 5'd5, 5'd5, 1, 0, 1, 0, 0, C_IDLE};
    vecs[3] = '{"not_load",    5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0, C_IDLE};
    vecs[4] = '{"rs2_match",   5'd1, 5'd5, 5'd5, 0, 1, 1, 0, 0, C_STALL};
    vecs[5] = '{"br_and_hz",   5'd5, 5'd0, 5'd5, 1, 0, 1, 1, 0, C_FLUSH};
    vecs[6] = '{"busy",        5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, C_FREEZE};
    vecs[7] = '{"busy_all",    5'd5, 5'd5, 5'd5, 1, 1, 1, 1, 1, C_FREEZE};
    vecs[8] = '{"idle",        5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, C_IDLE};
    vecs[9] = '{"rs1_unused",  5'd7, 5'd7, 5'd7, 0, 1, 1, 0, 0, C_STALL};
  end

  // ---------------- main sequence ----------------
  initial begin
    set_idle();
    reset_n = 1'b0;
    model_reset();
    #2;
    check("reset_ctrl0", {25'd0, ctrl_of(0)}, 32'd0);
    check("reset_sc0", sc0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle("post_reset");

    // Load-use, two bubbles on k=0.
    do_reset();
    set_hz();
    sample("lu_c1");
    check("lu_c1_stall", {31'd0, spc[0]}, 32'd1);
    check("lu_c1_bub", {31'd0, bub[0]}, 32'd1);
    adv();
    set_idle();
    sample("lu_c2");
    check("lu_c2_stall", {31'd0, spc[0]}, 32'd1);
    adv();
    sample("lu_c3");
    check("lu_c3_stall", {31'd0, spc[0]}, 32'd0);
    check("lu_cnt", sc0, 32'd2);
    adv();

    // Taken branch with a concurrent hazard.
    do_reset();
    set_hz();
    br = 1'b1;
    sample("br_c1");
    check("br_flush", {30'd0, fif[0], fid[0]}, 32'd3);
    check("br_nobub", {30'd0, bub[0], spc[0]}, 32'd0);
    adv();
    set_idle();
    sample("br_c2");
    check("br_c2_flush", {31'd0, fif[0]}, 32'd0);
    check("br_events", fe0, 32'd1);
    check("br_stallcnt", sc0, 32'd0);
    adv();

    // Freeze inside a three-bubble load stall on k=1.
    do_reset();
    set_hz();
    cycle("fz_hz");
    set_idle();
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample($sformatf("fz_busy%0d", i));
      check($sformatf("fz_busy%0d_k1", i), {25'd0, ctrl_of(1)}, {25'd0, C_FREEZE});
      adv();
    end
    busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample($sformatf("fz_tail%0d", i));
      check($sformatf("fz_tail%0d_k1", i), {25'd0, ctrl_of(1)}, {25'd0, C_STALL});
      adv();
    end
    sample("fz_done");
    check("fz_done_k1", {25'd0, ctrl_of(1)}, 32'd0);
    check("fz_cnt_k1", sc1, 32'd6);
    adv();

    // Asynchronous reset in the middle of a load stall.
    do_reset();
    set_hz();
    cycle("rs_hz");
    set_idle();
    sample("rs_pre");
    check("rs_pre_k1", {25'd0, ctrl_of(1)}, {25'd0, C_STALL});
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rs_async_k0", {25'd0, ctrl_of(0)}, 32'd0);
    check("rs_async_k1", {25'd0, ctrl_of(1)}, 32'd0);
    check("rs_async_cnt", sc1, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle("rs_post1");
    sample("rs_post2");
    check("rs_post_k1", {25'd0, ctrl_of(1)}, 32'd0);
    check("rs_post_cnt", sc1, 32'd0);
    adv();

    // Saturation of the 4-bit counter, then clear against a live stall.
    do_reset();
    busy = 1'b1;
    for (int i = 0; i < 20; i++) cycle($sformatf("sat%0d", i));
    sample("sat_end");
    check("sat_hold", {28'd0, sc2}, 32'd15);
    pclr = 1'b1;
    adv();
    pclr = 1'b0;
    sample("sat_clr");
    check("sat_clr_k2", {28'd0, sc2}, 32'd0);
    check("sat_clr_k0", sc0, 32'd0);
    adv();

    // Table of single-cycle vectors, each from RUN on k=0.
    do_reset();
    for (int v = 0; v < 10; v++) begin
      set_idle();
      rs1 = vecs[v].rs1; rs2 = vecs[v].rs2; rd = vecs[v].rd;
      u1 = vecs[v].u1; u2 = vecs[v].u2; load = vecs[v].load;
      br = vecs[v].br; busy = vecs[v].busy;
      sample($sformatf("vec_%s", vecs[v].name));
      check($sformatf("vec_%s_tbl", vecs[v].name), {25'd0, ctrl_of(0)}, {25'd0, vecs[v].exp});
      adv();
      set_idle();
      for (int j = 0; j < 3; j++) cycle($sformatf("vec_%s_drain%0d", vecs[v].name, j));
    end

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      rs1  = 5'($urandom_range(0, 3));
      rs2  = 5'($urandom_range(0, 3));
      rd   = 5'($urandom_range(0, 3));
      u1   = 1'($urandom_range(0, 1));
      u2   = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 1) == 1);
      br   = ($urandom_range(0, 7) == 0);
      busy = ($urandom_range(0, 5) == 0);
      pclr = ($urandom_range(0, 31) == 0);
      cycle($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
